// File: rtl/pong_pkg.sv
// Shared definitions for the pong game controller: FSM encoding, field geometry
// constants and small arithmetic helpers used by the ball/score datapath.
// Latency: n/a (package). Backpressure: n/a.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [3:0] FIELD_MAX   = 4'd15;
    localparam logic [3:0] CENTER      = 4'd8;
    localparam logic [3:0] BALL_X_MIN  = 4'd1;
    localparam logic [3:0] BALL_X_MAX  = 4'd14;
    localparam int         PADDLE_HALF = 1;

    // |ball_y - pos| <= PADDLE_HALF, done in 5-bit signed so rows 0 and 15
    // never alias onto each other.
    function automatic logic paddle_hit(input logic [3:0] ball_y, input logic [3:0] pos);
        logic signed [4:0] diff;
        logic signed [4:0] half;
        half = 5'(PADDLE_HALF);
        diff = $signed({1'b0, ball_y}) - $signed({1'b0, pos});
        return (diff >= -half) && (diff <= half);
    endfunction

    // Scores stop at 15 rather than wrapping back to 0.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == FIELD_MAX) ? s : s + 4'd1;
    endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Frame tick generator: free-running divider, one-cycle tick every TICK_DIV clocks.
// Latency: tick is combinational from the counter (high while count = TICK_DIV-1).
// Backpressure: none; runs in every state, cleared only by rst.
// Ports: clk, rst (async, active-high) in; tick out.
module pong_tick_gen #(
    parameter int TICK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pong_ctrl.sv
// Pong game controller: frame tick, ball motion, scoring, game FSM and paddle move pulses.
// Latency: all outputs registered; on tick cycle T, ball/score/state and move pulses appear at T+1.
// Backpressure: none; buttons sampled on tick only, start sampled every clock in IDLE/OVER.
// Ports: clk, rst, start, four raw buttons, paddle rows pos_l/pos_r in;
//        l_up/l_dn/r_up/r_dn pulses, ball_x/ball_y, score_l/score_r, state, winner out.
module pong_ctrl
    import pong_pkg::*;
#(
    parameter int TICK_DIV    = 1_000_000,
    parameter int SERVE_TICKS = 30,
    parameter int POINT_TICKS = 30,
    parameter int WIN_SCORE   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       btn_l_up,
    input  logic       btn_l_dn,
    input  logic       btn_r_up,
    input  logic       btn_r_dn,
    input  logic [3:0] pos_l,
    input  logic [3:0] pos_r,
    output logic       l_up,
    output logic       l_dn,
    output logic       r_up,
    output logic       r_dn,
    output logic [3:0] ball_x,
    output logic [3:0] ball_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [2:0] state,
    output logic       winner
);

    localparam int             TMAX        = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
    localparam int             TCW         = $clog2(TMAX + 1);
    localparam logic [TCW-1:0] SERVE_LAST  = TCW'(SERVE_TICKS - 1);
    localparam logic [TCW-1:0] POINT_LAST  = TCW'(POINT_TICKS - 1);
    localparam logic [3:0]     WIN         = 4'(WIN_SCORE);

    logic tick;

    pong_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_e         state_q,   state_d;
    logic [3:0]     ball_x_q,  ball_x_d;
    logic [3:0]     ball_y_q,  ball_y_d;
    logic [3:0]     score_l_q, score_l_d;
    logic [3:0]     score_r_q, score_r_d;
    logic           dx_neg_q,  dx_neg_d;   // 1: dx = -1, 0: dx = +1
    logic           dy_neg_q,  dy_neg_d;   // 1: dy = -1, 0: dy = +1
    logic           winner_q,  winner_d;
    logic [TCW-1:0] tcnt_q,    tcnt_d;     // ticks spent in SERVE or POINT
    logic           l_up_q, l_up_d, l_dn_q, l_dn_d;
    logic           r_up_q, r_up_d, r_dn_q, r_dn_d;

    // Vertical step: bounce off the top/bottom row before moving.
    logic       dy_flip;
    logic       dy_step_neg;
    logic [3:0] ball_y_step;
    logic       hit_l;
    logic       hit_r;
    logic       move_en;

    assign dy_flip     = ((ball_y_q == FIELD_MAX) && !dy_neg_q) ||
                         ((ball_y_q == 4'd0) && dy_neg_q);
    assign dy_step_neg = dy_neg_q ^ dy_flip;
    assign ball_y_step = dy_step_neg ? (ball_y_q - 4'd1) : (ball_y_q + 4'd1);

    // Paddle rows are sampled on the tick itself, i.e. before this tick's move lands.
    assign hit_l = paddle_hit(ball_y_q, pos_l);
    assign hit_r = paddle_hit(ball_y_q, pos_r);

    // Move pulses: one per paddle per tick, only while the ball is live or serving.
    // Pressing both buttons cancels out; rows 0 and 15 clamp the move.
    assign move_en = tick && ((state_q == ST_SERVE) || (state_q == ST_PLAY));
    assign l_up_d  = move_en && btn_l_up && !btn_l_dn && (pos_l != FIELD_MAX);
    assign l_dn_d  = move_en && btn_l_dn && !btn_l_up && (pos_l != 4'd0);
    assign r_up_d  = move_en && btn_r_up && !btn_r_dn && (pos_r != FIELD_MAX);
    assign r_dn_d  = move_en && btn_r_dn && !btn_r_up && (pos_r != 4'd0);

    always_comb begin
        state_d   = state_q;
        ball_x_d  = ball_x_q;
        ball_y_d  = ball_y_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        dx_neg_d  = dx_neg_q;
        dy_neg_d  = dy_neg_q;
        winner_d  = winner_q;
        tcnt_d    = tcnt_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                // start is taken on any clock; it overrides a coinciding tick.
                if (start) begin
                    state_d   = ST_SERVE;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    ball_x_d  = CENTER;
                    ball_y_d  = CENTER;
                    dx_neg_d  = 1'b0;
                    dy_neg_d  = 1'b0;
                    tcnt_d    = '0;
                end
            end

            ST_SERVE: begin
                if (tick) begin
                    if (tcnt_q == SERVE_LAST) begin
                        state_d = ST_PLAY;
                        tcnt_d  = '0;
                    end else begin
                        tcnt_d  = tcnt_q + TCW'(1);
                    end
                end
            end

            ST_PLAY: begin
                if (tick) begin
                    // Vertical motion always applies, even on the tick a point is lost.
                    dy_neg_d = dy_step_neg;
                    ball_y_d = ball_y_step;

                    if ((ball_x_q == BALL_X_MIN) && dx_neg_q) begin
                        if (hit_l) begin
                            dx_neg_d = 1'b0;
                            ball_x_d = BALL_X_MIN + 4'd1;
                        end else begin
                            // Ball stays frozen in POINT, so dx can be preloaded
                            // here with the direction of the next serve.
                            score_r_d = sat_inc(score_r_q);
                            dx_neg_d  = 1'b0;
                            state_d   = ST_POINT;
                            tcnt_d    = '0;
                        end
                    end else if ((ball_x_q == BALL_X_MAX) && !dx_neg_q) begin
                        if (hit_r) begin
                            dx_neg_d = 1'b1;
                            ball_x_d = BALL_X_MAX - 4'd1;
                        end else begin
                            score_l_d = sat_inc(score_l_q);
                            dx_neg_d  = 1'b1;
                            state_d   = ST_POINT;
                            tcnt_d    = '0;
                        end
                    end else begin
                        ball_x_d = dx_neg_q ? (ball_x_q - 4'd1) : (ball_x_q + 4'd1);
                    end
                end
            end

            ST_POINT: begin
                if (tick) begin
                    if (tcnt_q == POINT_LAST) begin
                        tcnt_d = '0;
                        if ((score_l_q == WIN) || (score_r_q == WIN)) begin
                            state_d  = ST_OVER;
                            winner_d = (score_r_q == WIN);
                        end else begin
                            state_d  = ST_SERVE;
                            ball_x_d = CENTER;
                            ball_y_d = CENTER;
                            dy_neg_d = 1'b0;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TCW'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ball_x_q  <= CENTER;
            ball_y_q  <= CENTER;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            dx_neg_q  <= 1'b0;
            dy_neg_q  <= 1'b0;
            winner_q  <= 1'b0;
            tcnt_q    <= '0;
            l_up_q    <= 1'b0;
            l_dn_q    <= 1'b0;
            r_up_q    <= 1'b0;
            r_dn_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ball_x_q  <= ball_x_d;
            ball_y_q  <= ball_y_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            dx_neg_q  <= dx_neg_d;
            dy_neg_q  <= dy_neg_d;
            winner_q  <= winner_d;
            tcnt_q    <= tcnt_d;
            l_up_q    <= l_up_d;
            l_dn_q    <= l_dn_d;
            r_up_q    <= r_up_d;
            r_dn_q    <= r_dn_d;
        end
    end

    assign l_up    = l_up_q;
    assign l_dn    = l_dn_q;
    assign r_up    = r_up_q;
    assign r_dn    = r_dn_q;
    assign ball_x  = ball_x_q;
    assign ball_y  = ball_y_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;
    assign state   = state_q;
    assign winner  = winner_q;

endmodule

// File: tb/tb_pong_ctrl.sv
// Directed bench for pong_ctrl with TICK_DIV=4, SERVE_TICKS=2, POINT_TICKS=2, WIN_SCORE=2.
// Ticks land on every 4th clock edge after reset release; cyc counts those edges.
// Status word checked as {state, ball_x, ball_y, score_l, score_r}.
module tb_pong_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       btn_l_up = 1'b0, btn_l_dn = 1'b0, btn_r_up = 1'b0, btn_r_dn = 1'b0;
    logic [3:0] pos_l = 4'd4;
    logic [3:0] pos_r = 4'd14;
    logic       l_up, l_dn, r_up, r_dn;
    logic [3:0] ball_x, ball_y, score_l, score_r;
    logic [2:0] state;
    logic       winner;

    int          cyc;
    int          n_vec;
    int          n_err;
    logic [18:0] got, exp;
    logic [3:0]  pul, pexp;

    always #5 clk = ~clk;

    pong_ctrl #(
        .TICK_DIV    (4),
        .SERVE_TICKS (2),
        .POINT_TICKS (2),
        .WIN_SCORE   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .btn_l_up (btn_l_up),
        .btn_l_dn (btn_l_dn),
        .btn_r_up (btn_r_up),
        .btn_r_dn (btn_r_dn),
        .pos_l    (pos_l),
        .pos_r    (pos_r),
        .l_up     (l_up),
        .l_dn     (l_dn),
        .r_up     (r_up),
        .r_dn     (r_dn),
        .ball_x   (ball_x),
        .ball_y   (ball_y),
        .score_l  (score_l),
        .score_r  (score_r),
        .state    (state),
        .winner   (winner)
    );

    function automatic logic [18:0] snap();
        return {state, ball_x, ball_y, score_l, score_r};
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic tick_step();
        do step(); while (cyc % 4 != 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = snap(); exp = {3'd0, 4'd8, 4'd8, 4'd0, 4'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reset_status: got %h want %h", got, exp); end
        pul = {l_up, l_dn, r_up, r_dn}; n_vec++;
        if (pul !== 4'b0000) begin n_err++; $display("FAIL reset_pulses: got %b want 0000", pul); end
        n_vec++;
        if (winner !== 1'b0) begin n_err++; $display("FAIL reset_winner: got %b want 0", winner); end
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_serve();
        start = 1'b1;
        step();
        start = 1'b0;
        got = snap(); exp = {3'd1, 4'd8, 4'd8, 4'd0, 4'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL serve_entry: got %h want %h", got, exp); end
        tick_step();
        got = snap(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL serve_tick1: got %h want %h", got, exp); end
        tick_step();
        got = snap(); exp = {3'd2, 4'd8, 4'd8, 4'd0, 4'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL serve_to_play: got %h want %h", got, exp); end
        for (int k = 1; k <= 3; k++) begin
            tick_step();
            got = snap(); exp = {3'd2, 4'(8 + k), 4'(8 + k), 8'd0}; n_vec++;
            if (got !== exp) begin n_err++; $display("FAIL play_step%0d: got %h want %h", k, got, exp); end
        end
    endtask

    task automatic test_rally();
        repeat (3) tick_step();                       // k6: (14,14)
        tick_step();                                  // k7: right hit, y -> 15
        got = snap(); exp = {3'd2, 4'd13, 4'd15, 8'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL right_hit: got %h want %h", got, exp); end
        tick_step();                                  // k8: dy flips at 15
        got = snap(); exp = {3'd2, 4'd12, 4'd14, 8'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL top_bounce: got %h want %h", got, exp); end
        pos_r = 4'd2;
        repeat (11) tick_step();                      // k19
        got = snap(); exp = {3'd2, 4'd1, 4'd3, 8'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reach_left: got %h want %h", got, exp); end
        tick_step();                                  // k20: y=3, pos_l=4 edge hit
        got = snap(); exp = {3'd2, 4'd2, 4'd2, 8'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL left_edge_hit: got %h want %h", got, exp); end
        repeat (2) tick_step();                       // k22
        got = snap(); exp = {3'd2, 4'd4, 4'd0, 8'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reach_row0: got %h want %h", got, exp); end
        tick_step();                                  // k23: bottom bounce
        got = snap(); exp = {3'd2, 4'd5, 4'd1, 8'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL bottom_bounce: got %h want %h", got, exp); end
    endtask

    task automatic test_right_miss();
        repeat (9) tick_step();                       // k32
        got = snap(); exp = {3'd2, 4'd14, 4'd10, 8'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL pre_miss: got %h want %h", got, exp); end
        tick_step();                                  // k33: pos_r=2 misses
        got = snap(); exp = {3'd3, 4'd14, 4'd11, 4'd1, 4'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL right_miss: got %h want %h", got, exp); end
        tick_step();
        got = snap(); n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL point_hold: got %h want %h", got, exp); end
        tick_step();
        got = snap(); exp = {3'd1, 4'd8, 4'd8, 4'd1, 4'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL point_to_serve: got %h want %h", got, exp); end
        repeat (2) tick_step();
        got = snap(); exp = {3'd2, 4'd8, 4'd8, 4'd1, 4'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reserve_play: got %h want %h", got, exp); end
        tick_step();                                  // dx = -1 after right miss
        got = snap(); exp = {3'd2, 4'd7, 4'd9, 4'd1, 4'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL serve_dir_left: got %h want %h", got, exp); end
    endtask

    task automatic test_game_end();
        repeat (6) tick_step();                       // k44
        got = snap(); exp = {3'd2, 4'd1, 4'd15, 4'd1, 4'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reach_left2: got %h want %h", got, exp); end
        tick_step();                                  // k45: left miss
        got = snap(); exp = {3'd3, 4'd1, 4'd14, 4'd1, 4'd1}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL left_miss1: got %h want %h", got, exp); end
        pos_r = 4'd14;
        repeat (4) tick_step();                       // k49: PLAY
        got = snap(); exp = {3'd2, 4'd8, 4'd8, 4'd1, 4'd1}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL reserve_play2: got %h want %h", got, exp); end
        tick_step();                                  // dx = +1 after left miss
        got = snap(); exp = {3'd2, 4'd9, 4'd9, 4'd1, 4'd1}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL serve_dir_right: got %h want %h", got, exp); end
        repeat (6) tick_step();                       // k56: right hit
        got = snap(); exp = {3'd2, 4'd13, 4'd15, 4'd1, 4'd1}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL right_hit2: got %h want %h", got, exp); end
        pos_l = 4'd8;
        repeat (13) tick_step();                      // k69: second left miss
        got = snap(); exp = {3'd3, 4'd1, 4'd2, 4'd1, 4'd2}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL left_miss2: got %h want %h", got, exp); end
        repeat (2) tick_step();                       // k71
        got = snap(); exp = {3'd4, 4'd1, 4'd2, 4'd1, 4'd2}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL game_over: got %h want %h", got, exp); end
        n_vec++;
        if (winner !== 1'b1) begin n_err++; $display("FAIL winner_right: got %b want 1", winner); end
        tick_step();
        n_vec++;
        if (state !== 3'd4) begin n_err++; $display("FAIL over_holds: got %0d want 4", state); end
        start = 1'b1;
        step();
        start = 1'b0;
        got = snap(); exp = {3'd1, 4'd8, 4'd8, 4'd0, 4'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL restart: got %h want %h", got, exp); end
    endtask

    task automatic test_moves();
        pos_l = 4'd15; btn_l_up = 1'b1;
        pos_r = 4'd3;  btn_r_dn = 1'b1;
        repeat (2) step();                            // cycle before the tick
        pul = {l_up, l_dn, r_up, r_dn}; n_vec++;
        if (pul !== 4'b0000) begin n_err++; $display("FAIL pulse_off_tick: got %b want 0000", pul); end
        tick_step();
        pul = {l_up, l_dn, r_up, r_dn}; pexp = 4'b0001; n_vec++;
        if (pul !== pexp) begin n_err++; $display("FAIL r_dn_tick1: got %b want %b", pul, pexp); end
        step();
        pul = {l_up, l_dn, r_up, r_dn}; n_vec++;
        if (pul !== 4'b0000) begin n_err++; $display("FAIL pulse_width: got %b want 0000", pul); end
        tick_step();
        pul = {l_up, l_dn, r_up, r_dn}; n_vec++;
        if (pul !== pexp) begin n_err++; $display("FAIL r_dn_tick2: got %b want %b", pul, pexp); end
        btn_r_up = 1'b1;
        tick_step();
        pul = {l_up, l_dn, r_up, r_dn}; n_vec++;
        if (pul !== 4'b0000) begin n_err++; $display("FAIL both_buttons: got %b want 0000", pul); end
        btn_l_up = 1'b0; btn_l_dn = 1'b1;
        btn_r_up = 1'b0; pos_r = 4'd0;
        tick_step();
        pul = {l_up, l_dn, r_up, r_dn}; pexp = 4'b0100; n_vec++;
        if (pul !== pexp) begin n_err++; $display("FAIL l_dn_r_clamp: got %b want %b", pul, pexp); end
        pos_l = 4'd0; btn_r_dn = 1'b0; btn_r_up = 1'b1;
        tick_step();
        pul = {l_up, l_dn, r_up, r_dn}; pexp = 4'b0010; n_vec++;
        if (pul !== pexp) begin n_err++; $display("FAIL r_up_l_clamp: got %b want %b", pul, pexp); end
        got = snap(); exp = {3'd2, 4'd11, 4'd11, 8'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL moves_ball: got %h want %h", got, exp); end
    endtask

    task automatic test_reset_mid();
        btn_l_dn = 1'b0; btn_l_up = 1'b1; pos_l = 4'd5;
        repeat (3) step();
        rst = 1'b1;
        #1;
        got = snap(); exp = {3'd0, 4'd8, 4'd8, 4'd0, 4'd0}; n_vec++;
        if (got !== exp) begin n_err++; $display("FAIL mid_reset_status: got %h want %h", got, exp); end
        n_vec++;
        if (winner !== 1'b0) begin n_err++; $display("FAIL mid_reset_winner: got %b want 0", winner); end
        repeat (2) step();
        pul = {l_up, l_dn, r_up, r_dn}; n_vec++;
        if (pul !== 4'b0000) begin n_err++; $display("FAIL pulses_in_reset: got %b want 0000", pul); end
        n_vec++;
        if (state !== 3'd0) begin n_err++; $display("FAIL state_in_reset: got %0d want 0", state); end
        btn_l_up = 1'b0; btn_r_up = 1'b0;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_start_on_tick();
        repeat (3) step();
        start = 1'b1;
        step();                                       // edge 4 is also a tick
        start = 1'b0;
        n_vec++;
        if (state !== 3'd1) begin n_err++; $display("FAIL start_on_tick: got %0d want 1", state); end
        tick_step();
        n_vec++;
        if (state !== 3'd1) begin n_err++; $display("FAIL serve_count1: got %0d want 1", state); end
        tick_step();
        n_vec++;
        if (state !== 3'd2) begin n_err++; $display("FAIL serve_count2: got %0d want 2", state); end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        test_reset();
        test_serve();
        test_rally();
        test_right_miss();
        test_game_end();
        test_moves();
        test_reset_mid();
        test_start_on_tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
